axis_write_resp: RTL and testbench



---
 rtl/axis_write_resp_pkg.sv | 31 +++
 rtl/cfg_decode.sv | 52 +++++
 rtl/axis_write_resp.sv | 156 +++++++++++++++
 tb/tb_axis_write_resp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_write_resp_pkg.sv
// Shared definitions for the AXI write-response tracker and its stream engines.
//   - one-hot state encodings and their bit indices
//   - AXI BRESP codes and an error-class helper
package axis_write_resp_pkg;

  localparam int unsigned ST_W = 4;

  // Bit position of each state inside the one-hot state vector
  localparam int unsigned IDX_IDLE   = 0;
  localparam int unsigned IDX_CONFIG = 1;
  localparam int unsigned IDX_RUN    = 2;
  localparam int unsigned IDX_DONE   = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 4'b0001;
  localparam logic [ST_W-1:0] S_CONFIG = 4'b0010;
  localparam logic [ST_W-1:0] S_RUN    = 4'b0100;
  localparam logic [ST_W-1:0] S_DONE   = 4'b1000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  // SLVERR and DECERR are the two failing response codes
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/cfg_decode.sv
// Registered cfg-bus front end shared by the stream engines.
// The bus beat is captured once, then decoded, so every action lands one
// cycle after the beat.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cfg_addr_i/data_i   cfg bus address/data
//   cfg_valid_i         cfg bus strobe
//   arm_c_o             registered beat at ARM_ADDR carrying ARM_ID (decoded)
//   load_c_o            registered beat at DATA_ADDR (decoded)
//   data_o              registered cfg data word
module cfg_decode
  import axis_write_resp_pkg::*;
#(
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned ARM_ADDR  = 25,
  parameter int unsigned ARM_ID    = 1,
  parameter int unsigned DATA_ADDR = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] cfg_addr_i,
  input  logic [DWIDTH-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              arm_c_o,
  output logic              load_c_o,
  output logic [DWIDTH-1:0] data_o
);

  logic              valid_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;

  // Capture the bus beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= cfg_valid_i;
      addr_q  <= cfg_addr_i;
      data_q  <= cfg_data_i;
    end
  end

  // Decode the captured beat
  assign arm_c_o  = valid_q && (addr_q == AWIDTH'(ARM_ADDR)) && (data_q == DWIDTH'(ARM_ID));
  assign load_c_o = valid_q && (addr_q == AWIDTH'(DATA_ADDR));
  assign data_o   = data_q;

endmodule

// File: rtl/axis_write_resp.sv
// AXI write-response tracker: gates AW issue against an outstanding-burst
// limit, drains B responses, and counts responses toward an armed target N.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_addr/cfg_data/cfg_valid     cfg bus (ID arm beat, burst-count beat)
//   s_awvalid/s_awready             AW from the upstream write engine
//   m_awvalid/m_awready             AW to the interconnect
//   axi_bresp/axi_bvalid/axi_bready write response channel
//   done                            one-cycle completion pulse
//   error                           sticky SLVERR/DECERR flag
//   busy                            bursts in flight
//   outstanding                     count of bursts in flight
module axis_write_resp
  import axis_write_resp_pkg::*;
#(
  parameter int unsigned CFG_ID     = 1,
  parameter int unsigned CFG_ADDR   = 25,
  parameter int unsigned CFG_DATA   = 26,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned MAX_OUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CFG_AWIDTH-1:0]    cfg_addr,
  input  logic [CFG_DWIDTH-1:0]    cfg_data,
  input  logic                     cfg_valid,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  output logic                     axi_bready,
  output logic                     done,
  output logic                     error,
  output logic                     busy,
  output logic [$clog2(MAX_OUT):0] outstanding
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;
  localparam int unsigned CNT_W = 32;

  logic                  arm_c;
  logic                  load_c;
  logic [CFG_DWIDTH-1:0] load_data;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_q, out_d;

  logic room_c;
  logic aw_hs_c;
  logic b_hs_c;

  cfg_decode #(
    .AWIDTH    (CFG_AWIDTH),
    .DWIDTH    (CFG_DWIDTH),
    .ARM_ADDR  (CFG_ADDR),
    .ARM_ID    (CFG_ID),
    .DATA_ADDR (CFG_DATA)
  ) u_cfg_decode (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .cfg_valid_i (cfg_valid),
    .arm_c_o     (arm_c),
    .load_c_o    (load_c),
    .data_o      (load_data)
  );

  // AW gating and B acceptance run in every state
  assign room_c     = out_q < OUT_W'(MAX_OUT);
  assign m_awvalid  = s_awvalid & room_c;
  assign s_awready  = m_awready & room_c;
  assign axi_bready = (out_q != '0);
  assign aw_hs_c    = m_awvalid & m_awready;
  assign b_hs_c     = axi_bvalid & axi_bready;

  // In-flight count; gating above keeps it within 0..MAX_OUT
  always_comb begin
    out_d = out_q;
    if (aw_hs_c && !b_hs_c) begin
      out_d = out_q + OUT_W'(1);
    end else if (b_hs_c && !aw_hs_c) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  // Next-state: arm, load N, count responses, pulse done
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (arm_c) begin
          state_d = S_CONFIG;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CONFIG: begin
        if (load_c) begin
          n_d     = CNT_W'(load_data);
          state_d = (n_d == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Re-arm beats are ignored here; only responses matter
        if (b_hs_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A failing response is never lost, even on the arming cycle
    if (b_hs_c && resp_is_err(axi_bresp)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign done        = state_q[IDX_DONE];
  assign error       = err_q;
  assign busy        = (out_q != '0);
  assign outstanding = out_q;

endmodule

// File: tb/tb_axis_write_resp.sv
// Self-checking bench for axis_write_resp: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference.
module tb_axis_write_resp;

  localparam int unsigned MAXO = 16;

  logic        clk;
  logic        rst_n;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        s_awvalid;
  logic        s_awready;
  logic        m_awvalid;
  logic        m_awready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        done;
  logic        error;
  logic        busy;
  logic [4:0]  outstanding;

  axis_write_resp #(
    .CFG_ID(1), .CFG_ADDR(25), .CFG_DATA(26),
    .CFG_AWIDTH(5), .CFG_DWIDTH(32), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .done(done), .error(error), .busy(busy), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: phase name, queue of in-flight bursts, response tally
  typedef enum int {M_IDLE, M_CONFIG, M_RUN, M_DONE} mphase_e;
  mphase_e     m_ph;
  int          inflight[$];
  int          burst_seq;
  int unsigned m_cnt;
  int unsigned m_n;
  bit          m_err;
  bit          p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  int          done_cnt;

  task automatic model_reset();
    m_ph = M_IDLE;
    inflight.delete();
    m_cnt = 0;
    m_n = 0;
    m_err = 0;
    p_valid = 0;
    p_addr = '0;
    p_data = '0;
  endtask

  task automatic model_step(input bit aw, input bit b);
    bit arm;
    bit load;
    arm  = p_valid && (p_addr == 5'd25) && (p_data == 32'd1);
    load = p_valid && (p_addr == 5'd26);
    case (m_ph)
      M_IDLE:   if (arm) begin m_ph = M_CONFIG; m_cnt = 0; m_err = 0; end
      M_CONFIG: if (load) begin m_n = p_data; m_ph = (m_n == 0) ? M_DONE : M_RUN; end
      M_RUN: begin
        if (b) m_cnt++;
        if (m_cnt == m_n) m_ph = M_DONE;
      end
      default:  m_ph = M_IDLE;
    endcase
    if (b && (axi_bresp == 2'd2 || axi_bresp == 2'd3)) m_err = 1;
    if (b) void'(inflight.pop_front());
    if (aw) begin inflight.push_back(burst_seq); burst_seq++; end
    p_valid = cfg_valid;
    p_addr  = cfg_addr;
    p_data  = cfg_data;
  endtask

  // One clock: check all outputs late in the cycle, advance the model, cross the edge
  task automatic tick();
    bit room;
    bit aw;
    bit b;
    #3;
    room = inflight.size() < MAXO;
    check_eq("m_awvalid",   m_awvalid,   64'(s_awvalid & room));
    check_eq("s_awready",   s_awready,   64'(m_awready & room));
    check_eq("axi_bready",  axi_bready,  64'(inflight.size() != 0));
    check_eq("busy",        busy,        64'(inflight.size() != 0));
    check_eq("outstanding", outstanding, 64'(inflight.size()));
    check_eq("done",        done,        64'(m_ph == M_DONE));
    check_eq("error",       error,       64'(m_err));
    if (done === 1'b1) done_cnt++;
    aw = s_awvalid && room && m_awready;
    b  = axi_bvalid && (inflight.size() != 0);
    model_step(aw, b);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 0; cfg_addr = '0; cfg_data = '0;
    s_awvalid = 0; m_awready = 0; axi_bvalid = 0; axi_bresp = 2'd0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic cfg_beat(input logic [4:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_data = d; cfg_valid = 1;
    tick();
    cfg_valid = 0;
  endtask

  task automatic aw_burst(input int n);
    s_awvalid = 1; m_awready = 1;
    repeat (n) tick();
    s_awvalid = 0; m_awready = 0;
  endtask

  task automatic resp(input logic [1:0] code);
    axi_bvalid = 1; axi_bresp = code;
    tick();
    axi_bvalid = 0; axi_bresp = 2'd0;
  endtask

  // Assert reset away from the edge; outputs must clear without a clock
  task automatic do_reset();
    rst_n = 0;
    #1;
    check_eq("rst_done",        done,        0);
    check_eq("rst_error",       error,       0);
    check_eq("rst_busy",        busy,        0);
    check_eq("rst_axi_bready",  axi_bready,  0);
    check_eq("rst_outstanding", outstanding, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    int dc0;
    int sel;
    burst_seq = 0;
    done_cnt = 0;
    clear_inputs();
    rst_n = 0;
    #2;
    check_eq("por_done",        done,        0);
    check_eq("por_error",       error,       0);
    check_eq("por_busy",        busy,        0);
    check_eq("por_outstanding", outstanding, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);

    // Arm N=3, three bursts, three OKAY responses
    cfg_beat(5'd25, 32'd1);
    cfg_beat(5'd26, 32'd3);
    idle(2);
    aw_burst(3);
    dc0 = done_cnt;
    resp(2'd0);
    resp(2'd0);
    resp(2'd0);
    check_eq("n3_done_after_third_b", done, 1);
    idle(3);
    check_eq("n3_done_pulses", done_cnt - dc0, 1);
    check_eq("n3_error", error, 0);

    // Saturate the outstanding limit
    s_awvalid = 1; m_awready = 1;
    repeat (20) tick();
    check_eq("sat_outstanding", outstanding, MAXO);
    check_eq("sat_m_awvalid",   m_awvalid,   0);
    check_eq("sat_s_awready",   s_awready,   0);
    clear_inputs();
    axi_bvalid = 1;
    repeat (11) tick();
    clear_inputs();
    check_eq("drain_to_5", outstanding, 5);

    // Simultaneous AW and B handshakes
    s_awvalid = 1; m_awready = 1; axi_bvalid = 1;
    tick();
    clear_inputs();
    check_eq("both_hs_hold", outstanding, 5);
    axi_bvalid = 1;
    repeat (5) tick();
    clear_inputs();
    check_eq("drained_busy", busy, 0);

    // N=2 with an SLVERR response
    cfg_beat(5'd25, 32'd1);
    cfg_beat(5'd26, 32'd2);
    idle(2);
    aw_burst(2);
    dc0 = done_cnt;
    resp(2'd0);
    resp(2'd2);
    check_eq("slverr_error_next", error, 1);
    idle(2);
    check_eq("slverr_done_pulses", done_cnt - dc0, 1);
    cfg_beat(5'd25, 32'd1);
    idle(1);
    check_eq("rearm_clears_error", error, 0);

    // N=0: done two cycles after the count beat
    dc0 = done_cnt;
    cfg_beat(5'd26, 32'd0);
    check_eq("n0_done_not_yet", done, 0);
    tick();
    check_eq("n0_done", done, 1);
    idle(2);
    check_eq("n0_done_pulses", done_cnt - dc0, 1);

    // Reset in RUN with two bursts outstanding
    cfg_beat(5'd25, 32'd1);
    cfg_beat(5'd26, 32'd5);
    idle(2);
    aw_burst(2);
    check_eq("run_outstanding", outstanding, 2);
    dc0 = done_cnt;
    do_reset();
    idle(5);
    cfg_beat(5'd26, 32'd1);
    idle(4);
    check_eq("no_done_after_reset", done_cnt - dc0, 0);

    // Random traffic with alternating AW/B bias
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cfg_valid = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       begin cfg_addr = 5'd25; cfg_data = 32'd1; end
        1:       begin cfg_addr = 5'd26; cfg_data = 32'($urandom_range(0, 4)); end
        2:       begin cfg_addr = 5'd25; cfg_data = $urandom; end
        default: begin cfg_addr = 5'($urandom_range(0, 31)); cfg_data = $urandom; end
      endcase
      if (((i / 150) % 2) == 0) begin
        s_awvalid  = ($urandom_range(0, 3) != 0);
        m_awready  = ($urandom_range(0, 3) != 0);
        axi_bvalid = ($urandom_range(0, 3) == 0);
      end else begin
        s_awvalid  = ($urandom_range(0, 3) == 0);
        m_awready  = ($urandom_range(0, 1) == 0);
        axi_bvalid = ($urandom_range(0, 3) != 0);
      end
      axi_bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      tick();
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
